// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if: request/response bundle between two shift requesters, the arbiter and its consumer.
interface shift_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [1:0]  req0_op;
    logic [31:0] req0_a;
    logic [4:0]  req0_shamt;
    logic        req1_valid;
    logic        req1_ready;
    logic [1:0]  req1_op;
    logic [31:0] req1_a;
    logic [4:0]  req1_shamt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_id;
    modport master (
        output req0_valid, req0_op, req0_a, req0_shamt,
        output req1_valid, req1_op, req1_a, req1_shamt,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
    );
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_shamt,
        input  req1_valid, req1_op, req1_a, req1_shamt,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: arbitrates two requesters onto one left barrel shifter and
// sequences SLL, SRL and SRA, with right shifts built by bit reversal.
module sll (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);
    logic unused_b;
    assign unused_b = ^b[31:5];
    assign result = a << b[4:0];
endmodule

module shift_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input logic           clk,
    input logic           rst,
    shift_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, MASK, RESP} state_t;
    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d, res_q, res_d;
    logic [4:0]  shamt_q, shamt_d;
    logic        id_q, id_d, last_q, last_d;
    logic        gnt1, acc, right, sra;
    logic [31:0] sh_a, sh_res;

    function automatic logic [31:0] rev(input logic [31:0] x);
        for (int i = 0; i < 32; i++) rev[i] = x[31-i];
    endfunction

    sll u_sll (.a(sh_a), .b({27'd0, shamt_q}), .result(sh_res));

    always_comb begin
        gnt1 = bus.req1_valid && (!bus.req0_valid || (RR_EN && !last_q));
        bus.req0_ready = !rst && state_q == IDLE && bus.req0_valid && !gnt1;
        bus.req1_ready = !rst && state_q == IDLE && gnt1;
        acc = bus.req0_ready || bus.req1_ready;
        right = ^op_q;
        sra = op_q == 2'b10;
        sh_a = state_q == MASK ? 32'hFFFF_FFFF : right ? rev(a_q) : a_q;
        bus.rsp_valid = !rst && state_q == RESP;
        bus.rsp_data = res_q;
        bus.rsp_id = id_q;
        state_d = state_q;
        op_d = op_q;
        a_d = a_q;
        shamt_d = shamt_q;
        id_d = id_q;
        last_d = last_q;
        res_d = res_q;
        if (acc) begin
            op_d = gnt1 ? bus.req1_op : bus.req0_op;
            a_d = gnt1 ? bus.req1_a : bus.req0_a;
            shamt_d = gnt1 ? bus.req1_shamt : bus.req0_shamt;
            id_d = gnt1;
            last_d = gnt1;
            state_d = EXEC;
        end
        if (state_q == EXEC) begin
            res_d = right ? rev(sh_res) : sh_res;
            state_d = sra ? MASK : RESP;
        end
        // The mask pass shifts all-ones; its inverted, reversed image marks the vacated high bits.
        if (state_q == MASK) begin
            res_d = a_q[31] ? res_q | rev(~sh_res) : res_q;
            state_d = RESP;
        end
        if (state_q == RESP && bus.rsp_ready) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q <= '0;
            a_q <= '0;
            shamt_q <= '0;
            id_q <= 1'b0;
            last_q <= 1'b1;
            res_q <= '0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            a_q <= a_d;
            shamt_q <= shamt_d;
            id_q <= id_d;
            last_q <= last_d;
            res_q <= res_d;
        end
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed checks of shift_arbiter with round-robin and fixed-priority instances.
module tb_shift_arbiter;
    logic clk, rst;
    int n_cmp = 0, n_err = 0;
    shift_arbiter_if b ();
    shift_arbiter_if f ();

    shift_arbiter #(.RR_EN(1'b1)) u_rr (.clk(clk), .rst(rst), .bus(b));
    shift_arbiter #(.RR_EN(1'b0)) u_fp (.clk(clk), .rst(rst), .bus(f));

    assign f.req0_valid = b.req0_valid;
    assign f.req0_op    = b.req0_op;
    assign f.req0_a     = b.req0_a;
    assign f.req0_shamt = b.req0_shamt;
    assign f.req1_valid = b.req1_valid;
    assign f.req1_op    = b.req1_op;
    assign f.req1_a     = b.req1_a;
    assign f.req1_shamt = b.req1_shamt;
    assign f.rsp_ready  = b.rsp_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic id, input logic [1:0] op, input logic [31:0] a,
                         input logic [4:0] sh, input logic [31:0] exp, input int lat_exp);
        int w, lat;
        if (id) begin
            b.req1_valid = 1'b1; b.req1_op = op; b.req1_a = a; b.req1_shamt = sh;
        end else begin
            b.req0_valid = 1'b1; b.req0_op = op; b.req0_a = a; b.req0_shamt = sh;
        end
        w = 0;
        #1;
        while (!(id ? b.req1_ready : b.req0_ready) && w < 10) begin
            @(negedge clk); #1; w++;
        end
        chk({tag, "_accept"}, 32'(w < 10), 32'd1);
        @(negedge clk);
        b.req0_valid = 1'b0;
        b.req1_valid = 1'b0;
        lat = 1;
        while (!b.rsp_valid && lat < 8) begin
            @(negedge clk); lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        chk({tag, "_data"}, b.rsp_data, exp);
        chk({tag, "_id"}, 32'(b.rsp_id), 32'(id));
        @(negedge clk);
    endtask

    initial begin
        int cnt, lat;
        rst = 1'b1;
        b.req0_valid = 1'b1; b.req0_op = 2'd0; b.req0_a = '0; b.req0_shamt = '0;
        b.req1_valid = 1'b0; b.req1_op = 2'd0; b.req1_a = '0; b.req1_shamt = '0;
        b.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rsp_valid", 32'(b.rsp_valid), 32'd0);
        chk("rst_rsp_data", b.rsp_data, 32'd0);
        chk("rst_rsp_id", 32'(b.rsp_id), 32'd0);
        chk("rst_ready0", 32'(b.req0_ready), 32'd0);
        chk("rst_ready1", 32'(b.req1_ready), 32'd0);
        b.req0_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        issue("sll31", 1'b0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 2);
        issue("srl4", 1'b1, 2'b01, 32'h8000_00F0, 5'd4, 32'h0800_000F, 2);
        issue("sra4", 1'b1, 2'b10, 32'h8000_00F0, 5'd4, 32'hF800_000F, 3);
        issue("sra31_pos", 1'b0, 2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 3);
        issue("sra31_neg", 1'b0, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 3);
        issue("sll0", 1'b1, 2'b00, 32'hA5A5_1234, 5'd0, 32'hA5A5_1234, 2);
        issue("srl0", 1'b0, 2'b01, 32'hA5A5_1234, 5'd0, 32'hA5A5_1234, 2);
        issue("sra0", 1'b1, 2'b10, 32'h8000_0001, 5'd0, 32'h8000_0001, 3);
        issue("op11", 1'b0, 2'b11, 32'h0000_0003, 5'd2, 32'h0000_000C, 2);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        b.req0_valid = 1'b1; b.req0_op = 2'b00; b.req0_a = 32'd1; b.req0_shamt = 5'd1;
        b.req1_valid = 1'b1; b.req1_op = 2'b00; b.req1_a = 32'd1; b.req1_shamt = 5'd2;
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            while (!b.rsp_valid && cnt < 10) begin
                @(negedge clk); cnt++;
            end
            chk("rr_seen", 32'(cnt < 10), 32'd1);
            chk("rr_id", 32'(b.rsp_id), 32'(k & 1));
            chk("rr_data", b.rsp_data, (k & 1) ? 32'd4 : 32'd2);
            chk("fp_id", 32'(f.rsp_id), 32'd0);
            chk("fp_data", f.rsp_data, 32'd2);
            @(negedge clk);
        end
        b.req0_valid = 1'b0;
        b.req1_valid = 1'b0;
        repeat (2) @(negedge clk);

        b.rsp_ready = 1'b0;
        b.req0_valid = 1'b1; b.req0_op = 2'b00; b.req0_a = 32'h1234_5678; b.req0_shamt = 5'd4;
        #1;
        chk("stall_accept", 32'(b.req0_ready), 32'd1);
        @(negedge clk);
        b.req0_valid = 1'b0;
        b.req1_valid = 1'b1; b.req1_op = 2'b01; b.req1_a = 32'h0000_00FF; b.req1_shamt = 5'd4;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("stall_valid", 32'(b.rsp_valid), 32'd1);
            chk("stall_data", b.rsp_data, 32'h2345_6780);
            chk("stall_id", 32'(b.rsp_id), 32'd0);
            chk("stall_ready0", 32'(b.req0_ready), 32'd0);
            chk("stall_ready1", 32'(b.req1_ready), 32'd0);
            @(negedge clk);
        end
        b.rsp_ready = 1'b1;
        #1;
        chk("release_ready1", 32'(b.req1_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("release_valid", 32'(b.rsp_valid), 32'd0);
        chk("release_accept", 32'(b.req1_ready), 32'd1);
        @(negedge clk);
        b.req1_valid = 1'b0;
        @(negedge clk);
        chk("held_valid", 32'(b.rsp_valid), 32'd1);
        chk("held_data", b.rsp_data, 32'h0000_000F);
        chk("held_id", 32'(b.rsp_id), 32'd1);
        @(negedge clk);

        b.req0_valid = 1'b1; b.req0_op = 2'b10; b.req0_a = 32'h8000_0000; b.req0_shamt = 5'd4;
        #1;
        chk("abort_accept", 32'(b.req0_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        b.req0_op = 2'b00; b.req0_a = 32'd5; b.req0_shamt = 5'd1;
        b.req1_valid = 1'b1; b.req1_op = 2'b00; b.req1_a = 32'd7; b.req1_shamt = 5'd1;
        #1;
        chk("abort_rst_ready0", 32'(b.req0_ready), 32'd0);
        chk("abort_rst_ready1", 32'(b.req1_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_valid", 32'(b.rsp_valid), 32'd0);
        chk("abort_tie_ready0", 32'(b.req0_ready), 32'd1);
        chk("abort_tie_ready1", 32'(b.req1_ready), 32'd0);
        @(negedge clk);
        b.req0_valid = 1'b0;
        b.req1_valid = 1'b0;
        lat = 1;
        while (!b.rsp_valid && lat < 8) begin
            @(negedge clk); lat++;
        end
        chk("after_abort_lat", 32'(lat), 32'd2);
        chk("after_abort_data", b.rsp_data, 32'h0000_000A);
        chk("after_abort_id", 32'(b.rsp_id), 32'd0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
